// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the core fetch and data ports; one core step per pause release.
// Define MEM_ARB_IBUF_EN to add a one-entry fetch buffer that skips refetching an unchanged word.
module mem_arbiter #(
  parameter int unsigned TO_W   = 8,
  parameter int unsigned TO_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  output logic [31:0] i_ins_o,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wr_en,
  input  logic        d_rd_req,
  output logic [31:0] d_rdata_o,
  output logic        pause_o,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  output logic        m_we,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_REQ   = 2'd1,
    I_REQ   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [29:0]     i_word_q, i_word_d;
  logic            m_req_q, m_req_d;
  logic [31:0]     m_addr_q, m_addr_d;
  logic [31:0]     m_wdata_q, m_wdata_d;
  logic [3:0]      m_be_q, m_be_d;
  logic            m_we_q, m_we_d;
  logic [31:0]     ins_q, ins_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            pause_q, pause_d;

  logic            ack_c;
  logic            to_c;
  logic            done_c;
  logic            hit_idle_c;
  logic            hit_dack_c;
  logic            unused_ok;

  // Byte-offset bits are irrelevant to a word-addressed memory.
  assign unused_ok = ^{i_addr[1:0], d_addr[1:0]};

  assign ack_c  = m_ack & m_req_q;
  assign to_c   = ~ack_c & (cnt_q == TO_LAST);
  assign done_c = ack_c | to_c;

`ifdef MEM_ARB_IBUF_EN
  logic [29:0] tag_q;
  logic        valid_q;
  logic        inval_c;

  // A store finishing to the buffered word makes the buffer stale.
  assign inval_c    = (state_q == D_REQ) && done_c && m_we_q && (m_addr_q[31:2] == tag_q);
  assign hit_idle_c = valid_q && (i_addr[31:2] == tag_q);
  assign hit_dack_c = valid_q && !inval_c && (i_word_q == tag_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if ((state_q == I_REQ) && done_c) begin
      tag_q   <= i_word_q;
      valid_q <= ack_c;
    end else if (inval_c) begin
      valid_q <= 1'b0;
    end
  end
`else
  assign hit_idle_c = 1'b0;
  assign hit_dack_c = 1'b0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    i_word_d  = i_word_q;
    m_req_d   = m_req_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    m_we_d    = m_we_q;
    ins_d     = ins_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    pause_d   = 1'b1;

    case (state_q)
      IDLE: begin
        i_word_d = i_addr[31:2];
        cnt_d    = '0;
        if ((d_wr_en != 4'h0) || d_rd_req) begin
          state_d   = D_REQ;
          m_req_d   = 1'b1;
          m_addr_d  = {d_addr[31:2], 2'b00};
          m_wdata_d = d_wdata;
          m_we_d    = (d_wr_en != 4'h0);
          m_be_d    = (d_wr_en != 4'h0) ? d_wr_en : 4'hF;
        end else if (hit_idle_c) begin
          state_d = RELEASE;
          pause_d = 1'b0;
        end else begin
          state_d  = I_REQ;
          m_req_d  = 1'b1;
          m_addr_d = {i_addr[31:2], 2'b00};
          m_we_d   = 1'b0;
          m_be_d   = 4'hF;
        end
      end

      D_REQ: begin
        if (done_c) begin
          if (!m_we_q) begin
            rdata_d = ack_c ? m_rdata : 32'h0;
          end
          if (to_c) begin
            err_d = 1'b1;
          end
          cnt_d = '0;
          // Data goes first so a store in this step is seen by the fetch.
          if (hit_dack_c) begin
            state_d = RELEASE;
            pause_d = 1'b0;
            m_req_d = 1'b0;
            m_we_d  = 1'b0;
            m_be_d  = 4'h0;
          end else begin
            state_d  = I_REQ;
            m_req_d  = 1'b1;
            m_addr_d = {i_word_q, 2'b00};
            m_we_d   = 1'b0;
            m_be_d   = 4'hF;
          end
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      I_REQ: begin
        if (done_c) begin
          ins_d = ack_c ? m_rdata : 32'h0;
          if (to_c) begin
            err_d = 1'b1;
          end
          state_d = RELEASE;
          pause_d = 1'b0;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          m_be_d  = 4'h0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      i_word_q  <= '0;
      m_req_q   <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= 4'h0;
      m_we_q    <= 1'b0;
      ins_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      pause_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      i_word_q  <= i_word_d;
      m_req_q   <= m_req_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
      m_we_q    <= m_we_d;
      ins_q     <= ins_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      pause_q   <= pause_d;
    end
  end

  assign i_ins_o   = ins_q;
  assign d_rdata_o = rdata_q;
  assign pause_o   = pause_q;
  assign m_req     = m_req_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_be      = m_be_q;
  assign m_we      = m_we_q;
  assign bus_err_o = err_q;

endmodule
